// File: rtl/sum_prod_accumulator.sv
// rtl/sum_prod_accumulator.sv - frame accumulator of {sum, product} pairs with saturating totals
//
// Ports:
//   clk, rst            single rising-edge clock, synchronous active-high reset
//   clear               synchronous frame flush (drops partial or pending totals)
//   in_valid/in_ready   input pair handshake; in_ready is low only while a result is held
//   in_sum, in_product  unsigned operands
//   out_valid/out_ready result handshake; out_valid is high for the whole HOLD state
//   out_sum_acc         saturating total of in_sum over the frame
//   out_prod_acc        saturating total of in_product over the frame
//   out_ovf             sticky flag: either total clamped during this frame
module sum_prod_accumulator #(
    parameter int N_SAMPLES  = 4,
    parameter int SUM_W      = 9,
    parameter int PROD_W     = 16,
    parameter int SUM_ACC_W  = 12,
    parameter int PROD_ACC_W = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SUM_W-1:0]      in_sum,
    input  logic [PROD_W-1:0]     in_product,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SUM_ACC_W-1:0]  out_sum_acc,
    output logic [PROD_ACC_W-1:0] out_prod_acc,
    output logic                  out_ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] N_LAST = 8'(N_SAMPLES);

    state_t                  state, state_n;
    logic [SUM_ACC_W-1:0]    sum_acc, sum_n;
    logic [PROD_ACC_W-1:0]   prod_acc, prod_n;
    logic                    ovf, ovf_n;
    logic [7:0]              cnt, cnt_n;

    logic                    accept;
    logic [SUM_ACC_W:0]      sum_add;
    logic [PROD_ACC_W:0]     prod_add;
    logic [7:0]              cnt_inc;

    // Extra carry bit detects overflow; a clamped total stays all-ones because
    // any further non-zero add overflows again and clamps once more.
    assign sum_add  = {1'b0, sum_acc} + (SUM_ACC_W+1)'(in_sum);
    assign prod_add = {1'b0, prod_acc} + (PROD_ACC_W+1)'(in_product);
    assign cnt_inc  = cnt + 8'd1;

    // Ready depends on state only, so there is no path from out_ready.
    assign in_ready     = (state != HOLD);
    assign out_valid    = (state == HOLD);
    assign accept       = in_valid & in_ready;
    assign out_sum_acc  = sum_acc;
    assign out_prod_acc = prod_acc;
    assign out_ovf      = ovf;

    always_comb begin
        state_n = state;
        sum_n   = sum_acc;
        prod_n  = prod_acc;
        ovf_n   = ovf;
        cnt_n   = cnt;
        if (clear) begin
            state_n = IDLE;
            sum_n   = '0;
            prod_n  = '0;
            ovf_n   = 1'b0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sum_n   = SUM_ACC_W'(in_sum);
                        prod_n  = PROD_ACC_W'(in_product);
                        ovf_n   = 1'b0;
                        cnt_n   = 8'd1;
                        state_n = (N_LAST == 8'd1) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        sum_n   = sum_add[SUM_ACC_W] ? '1 : sum_add[SUM_ACC_W-1:0];
                        prod_n  = prod_add[PROD_ACC_W] ? '1 : prod_add[PROD_ACC_W-1:0];
                        ovf_n   = ovf | sum_add[SUM_ACC_W] | prod_add[PROD_ACC_W];
                        cnt_n   = cnt_inc;
                        if (cnt_inc == N_LAST) begin
                            state_n = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_n = IDLE;
                        sum_n   = '0;
                        prod_n  = '0;
                        ovf_n   = 1'b0;
                        cnt_n   = '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sum_acc  <= '0;
            prod_acc <= '0;
            ovf      <= 1'b0;
            cnt      <= '0;
        end else begin
            state    <= state_n;
            sum_acc  <= sum_n;
            prod_acc <= prod_n;
            ovf      <= ovf_n;
            cnt      <= cnt_n;
        end
    end

endmodule

// File: tb/tb_sum_prod_accumulator.sv
// tb/tb_sum_prod_accumulator.sv - directed bench for sum_prod_accumulator (default, 17-bit product, single-sample)
module tb_sum_prod_accumulator;

    logic        clk = 1'b0;
    logic        rst, clear, in_valid, out_ready;
    logic [8:0]  in_sum;
    logic [15:0] in_product;

    // default instance
    logic        d_in_ready, d_out_valid, d_ovf;
    logic [11:0] d_sum;
    logic [23:0] d_prod;
    // narrow product accumulator instance
    logic        s_in_ready, s_out_valid, s_ovf;
    logic [11:0] s_sum;
    logic [16:0] s_prod;
    // single-sample frame instance
    logic        o_in_ready, o_out_valid, o_ovf;
    logic [11:0] o_sum;
    logic [23:0] o_prod;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sum_prod_accumulator u_def (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(d_in_ready),
        .in_sum(in_sum), .in_product(in_product), .out_valid(d_out_valid), .out_ready(out_ready),
        .out_sum_acc(d_sum), .out_prod_acc(d_prod), .out_ovf(d_ovf)
    );

    sum_prod_accumulator #(.PROD_ACC_W(17)) u_sat (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_sum(in_sum), .in_product(in_product), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_sum_acc(s_sum), .out_prod_acc(s_prod), .out_ovf(s_ovf)
    );

    sum_prod_accumulator #(.N_SAMPLES(1)) u_one (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(o_in_ready),
        .in_sum(in_sum), .in_product(in_product), .out_valid(o_out_valid), .out_ready(out_ready),
        .out_sum_acc(o_sum), .out_prod_acc(o_prod), .out_ovf(o_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_sum = '0; in_product = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [8:0] s, input logic [15:0] p);
        in_valid = v; in_sum = s; in_product = p;
    endtask

    logic [8:0]  ps [4] = '{9'd109, 9'd43, 9'd165, 9'd136};
    logic [15:0] pp [4] = '{16'd990, 16'd330, 16'd4356, 16'd528};
    logic        gap [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        int k;
        rst = 1'b0; clear = 1'b0; out_ready = 1'b1; in_valid = 1'b0; in_sum = '0; in_product = '0;

        // reset state
        do_reset();
        chk("rst_in_ready", 32'(d_in_ready), 1);
        chk("rst_out_valid", 32'(d_out_valid), 0);
        chk("rst_sum", 32'(d_sum), 0);
        chk("rst_prod", 32'(d_prod), 0);
        chk("rst_ovf", 32'(d_ovf), 0);

        // basic frame, out_ready=1
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ps[i], pp[i]);
            tick();
            if (i < 3) chk("basic_no_valid_early", 32'(d_out_valid), 0);
        end
        drive(1'b0, 9'd0, 16'd0);
        chk("basic_valid", 32'(d_out_valid), 1);
        chk("basic_sum", 32'(d_sum), 453);
        chk("basic_prod", 32'(d_prod), 6204);
        chk("basic_ovf", 32'(d_ovf), 0);
        chk("basic_bubble", 32'(d_in_ready), 0);
        tick();
        chk("basic_done_valid", 32'(d_out_valid), 0);
        chk("basic_done_ready", 32'(d_in_ready), 1);
        chk("basic_done_sum", 32'(d_sum), 0);

        // backpressure, with a beat offered throughout HOLD
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ps[i], pp[i]);
            tick();
        end
        drive(1'b1, 9'd7, 16'd7);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(d_out_valid), 1);
            chk("bp_sum", 32'(d_sum), 453);
            chk("bp_prod", 32'(d_prod), 6204);
            chk("bp_in_ready", 32'(d_in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        drive(1'b0, 9'd0, 16'd0);
        chk("bp_done_valid", 32'(d_out_valid), 0);
        chk("bp_done_ready", 32'(d_in_ready), 1);
        chk("bp_done_sum", 32'(d_sum), 0);
        chk("bp_done_prod", 32'(d_prod), 0);

        // gapped input
        k = 0;
        for (int i = 0; i < 7; i++) begin
            if (gap[i]) begin
                drive(1'b1, ps[k], pp[k]);
                k++;
            end else begin
                drive(1'b0, 9'd511, 16'hffff);
            end
            tick();
            if (i == 5) chk("gap_no_valid", 32'(d_out_valid), 0);
        end
        drive(1'b0, 9'd0, 16'd0);
        chk("gap_valid", 32'(d_out_valid), 1);
        chk("gap_sum", 32'(d_sum), 453);
        chk("gap_prod", 32'(d_prod), 6204);
        tick();

        // saturation on the 17-bit product accumulator
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 9'd510, 16'd65025);
            tick();
            if (i == 1) chk("sat_ovf_beat2", 32'(s_ovf), 0);
            if (i == 1) chk("sat_prod_beat2", 32'(s_prod), 130050);
            if (i == 2) chk("sat_ovf_beat3", 32'(s_ovf), 1);
            if (i == 2) chk("sat_prod_beat3", 32'(s_prod), 131071);
        end
        drive(1'b0, 9'd0, 16'd0);
        chk("sat_valid", 32'(s_out_valid), 1);
        chk("sat_prod", 32'(s_prod), 131071);
        chk("sat_sum", 32'(s_sum), 2040);
        chk("sat_ovf", 32'(s_ovf), 1);
        tick();
        chk("sat_ovf_cleared", 32'(s_ovf), 0);
        chk("sat_prod_cleared", 32'(s_prod), 0);

        // clear with a simultaneous beat, then a fresh frame
        do_reset();
        drive(1'b1, 9'd10, 16'd20);
        tick();
        tick();
        clear = 1'b1;
        drive(1'b1, 9'd5, 16'd5);
        tick();
        clear = 1'b0;
        chk("clr_sum", 32'(d_sum), 0);
        chk("clr_prod", 32'(d_prod), 0);
        chk("clr_valid", 32'(d_out_valid), 0);
        chk("clr_ready", 32'(d_in_ready), 1);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 9'd1, 16'd1);
            tick();
        end
        drive(1'b0, 9'd0, 16'd0);
        chk("clr_frame_valid", 32'(d_out_valid), 1);
        chk("clr_frame_sum", 32'(d_sum), 4);
        chk("clr_frame_prod", 32'(d_prod), 4);

        // reset while holding a result
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        chk("rsthold_valid", 32'(d_out_valid), 0);
        chk("rsthold_sum", 32'(d_sum), 0);
        chk("rsthold_prod", 32'(d_prod), 0);
        chk("rsthold_ovf", 32'(d_ovf), 0);
        chk("rsthold_ready", 32'(d_in_ready), 1);

        // single-sample frames back to back
        do_reset();
        drive(1'b1, 9'd20, 16'd100);
        tick();
        drive(1'b1, 9'd30, 16'd200);
        chk("one_valid", 32'(o_out_valid), 1);
        chk("one_sum", 32'(o_sum), 20);
        chk("one_prod", 32'(o_prod), 100);
        chk("one_bubble", 32'(o_in_ready), 0);
        tick();
        chk("one_gap_valid", 32'(o_out_valid), 0);
        chk("one_gap_ready", 32'(o_in_ready), 1);
        tick();
        drive(1'b0, 9'd0, 16'd0);
        chk("one_second_valid", 32'(o_out_valid), 1);
        chk("one_second_sum", 32'(o_sum), 30);
        chk("one_second_prod", 32'(o_prod), 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sum_prod_accumulator.md
Name: sum_prod_accumulator

Overview:
- Downstream stage of the 8-bit sum/product datapath.
- Accepts one {sum, product} pair per valid/ready handshake and accumulates N_SAMPLES pairs into saturating running totals.
- Presents the frame result on a registered valid/ready output port, then clears its totals for the next frame.
- Single clock domain; feeds the result/display logic.

Parameters:
- N_SAMPLES, 4: pairs per frame; legal range 1..255.
- SUM_W, 9: input sum width.
- PROD_W, 16: input product width.
- SUM_ACC_W, 12: sum accumulator width; must be >= SUM_W.
- PROD_ACC_W, 24: product accumulator width; must be >= PROD_W.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- clear, input, 1: synchronous frame flush.
- in_valid, input, 1: upstream pair valid.
- in_ready, output, 1: block can accept a pair.
- in_sum, input, SUM_W: unsigned sum operand.
- in_product, input, PROD_W: unsigned product operand.
- out_valid, output, 1: frame result valid.
- out_ready, input, 1: downstream accepts the result.
- out_sum_acc, output, SUM_ACC_W: accumulated sums.
- out_prod_acc, output, PROD_ACC_W: accumulated products.
- out_ovf, output, 1: a saturation occurred in this frame.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. Port names are clk and rst.
- Reset values:
  - out_valid=0, out_sum_acc=0, out_prod_acc=0, out_ovf=0.
  - Internal beat counter=0; state=IDLE, so in_ready=1 in the cycle after reset.
- Priority: rst > clear > handshake activity.
- FSM states: IDLE, ACCUM, HOLD.
  - in_ready = (state != HOLD). Decoded from state only, with no combinational path from out_ready.
  - A beat is accepted on a rising edge with in_valid & in_ready.
- IDLE: accepted beat → load accumulators with the zero-extended inputs and set count=1. Go to ACCUM, or to HOLD if N_SAMPLES==1.
- ACCUM: accepted beat → add inputs to the accumulators and increment count. When the accepted beat makes count==N_SAMPLES, go to HOLD. No accepted beat → hold everything.
- HOLD:
  - out_valid=1 from the first HOLD cycle, i.e. the cycle after the Nth accept. Latency is 1 cycle.
  - out_sum_acc, out_prod_acc and out_ovf are stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: next cycle out_valid=0, accumulators=0, ovf=0, count=0, state=IDLE.
  - in_ready=0 throughout HOLD, so a beat presented in the handshake cycle is not accepted. There is exactly one bubble per frame.
- Arithmetic and saturation:
  - Unsigned addition with one extra carry bit.
  - If a result exceeds 2^W-1, the accumulator clamps to all-ones and ovf is set.
  - Once clamped, the accumulator stays all-ones for the rest of the frame.
  - ovf is sticky until the frame is consumed or flushed. The two accumulators saturate independently.
- clear: in any state, the next cycle has accumulators=0, ovf=0, count=0, out_valid=0 and state=IDLE. A beat offered in the same cycle as clear is dropped. A pending result in HOLD is discarded.
- Reset mid-frame: identical to the reset values above. Partial totals are lost.
- Outputs are observable in every state. They are meaningful only while out_valid=1.

Test Plan:
- Basic frame, N=4, out_ready=1: pairs (109,990), (43,330), (165,4356), (136,528), one per cycle → one cycle after the 4th accept, out_valid=1, out_sum_acc=453, out_prod_acc=6204, out_ovf=0. in_ready=0 for exactly one cycle.
- Backpressure: same frame with out_ready=0 for 5 cycles → out_valid stays 1 with values unchanged (453/6204) and in_ready=0. Raise out_ready → next cycle out_valid=0, in_ready=1, accumulators=0.
- Gapped input: in_valid toggled 1,0,0,1,1,0,1 over the same four pairs → same result (453/6204). The count advances only on accepted beats.
- Saturation, override PROD_ACC_W=17: four pairs (510,65025) → out_prod_acc=131071 and out_sum_acc=2040. out_ovf=1 from the 3rd beat onward, and is cleared after the result handshake.
- Clear/reset: clear asserted after 2 beats together with a 3rd beat → frame restarts. Four new pairs (1,1) give 4/4. rst asserted in HOLD → out_valid=0 next cycle and all outputs return to 0.
- N_SAMPLES=1 override: single pair (20,100) → out_valid=1 next cycle with 20/100. Back-to-back frames show one bubble cycle each.
